// File: rtl/countdown_sched.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_sched
//  Purpose  : Round-robin scheduler sharing one countdown/accumulate engine
//             among NREQ requesters. A granted job loads its run length into
//             the runner, then each cycle the runner decrements and the count
//             increments until the runner reaches zero. The engine then
//             reports the final count and the requester index.
//  Ports    : clk        - single clock, all state on posedge
//             rst        - synchronous reset, active-high
//             req        - level request per requester, held until done
//             req_len    - run length per requester, slice i = [i*LW +: LW]
//             grant      - one-hot grant, accept through DONE
//             busy       - high in RUN and DONE
//             runner     - remaining steps of the current job
//             count      - accumulated steps of the current job
//             done       - one-cycle completion pulse
//             done_id    - index of the completed requester (held)
//             done_count - final count of the completed job (held)
//  Options  : define COUNTDOWN_SCHED_TRACE_EN to print a per-step trace;
//             cycle behaviour is identical with or without it.
//  Revision : 1.0 - initial release
// ============================================================================
module countdown_sched #(
    parameter int NREQ = 4,
    parameter int LW   = 8,
    parameter int CW   = 32,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*LW-1:0]   req_len,
    output logic [NREQ-1:0]      grant,
    output logic                 busy,
    output logic [LW-1:0]        runner,
    output logic [CW-1:0]        count,
    output logic                 done,
    output logic [IDW-1:0]       done_id,
    output logic [CW-1:0]        done_count
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]       state_q,      state_d;
    logic [NREQ-1:0]  grant_q,      grant_d;
    logic [LW-1:0]    runner_q,     runner_d;
    logic [CW-1:0]    count_q,      count_d;
    logic             done_q,       done_d;
    logic [IDW-1:0]   done_id_q,    done_id_d;
    logic [CW-1:0]    done_count_q, done_count_d;
    logic [IDW-1:0]   ptr_q,        ptr_d;
    logic [IDW-1:0]   cur_id_q,     cur_id_d;

    // Arbiter results
    logic             w_found_hi;
    logic [IDW-1:0]   w_pick_hi;
    logic             w_found_any;
    logic [IDW-1:0]   w_pick_any;
    logic             w_found;
    logic [IDW-1:0]   w_pick;
    logic [LW-1:0]    w_len;
    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_ptr_next;

    // Round-robin pick: the lowest set request at or above the pointer wins;
    // if none exists, wrap around and take the lowest set request overall.
    // Loops run downward so the lowest matching index is the last written.
    always_comb begin
        w_found_hi  = 1'b0;
        w_pick_hi   = '0;
        w_found_any = 1'b0;
        w_pick_any  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_found_any = 1'b1;
                w_pick_any  = IDW'(i);
            end
            if (req[i] && (IDW'(i) >= ptr_q)) begin
                w_found_hi = 1'b1;
                w_pick_hi  = IDW'(i);
            end
        end
        w_found = w_found_any;
        w_pick  = w_found_hi ? w_pick_hi : w_pick_any;

        w_len   = '0;
        w_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == IDW'(i)) begin
                w_len      = req_len[i*LW +: LW];
                w_grant[i] = 1'b1;
            end
        end
    end

    // Pointer moves one past the requester just served, modulo NREQ.
    assign w_ptr_next = (cur_id_q == IDW'(NREQ - 1)) ? '0 : cur_id_q + IDW'(1);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        runner_d     = runner_q;
        count_d      = count_q;
        done_d       = 1'b0;
        done_id_d    = done_id_q;
        done_count_d = done_count_q;
        ptr_d        = ptr_q;
        cur_id_d     = cur_id_q;
        case (state_q)
            C_IDLE: begin
                if (w_found) begin
                    state_d  = C_RUN;
                    grant_d  = w_grant;
                    runner_d = w_len;
                    count_d  = '0;
                    cur_id_d = w_pick;
                end
            end
            C_RUN: begin
                // Runner only moves while nonzero, so it cannot underflow.
                if (runner_q != '0) begin
                    runner_d = runner_q - LW'(1);
                    count_d  = count_q + CW'(1);
                end else begin
                    state_d      = C_DONE;
                    done_d       = 1'b1;
                    done_id_d    = cur_id_q;
                    done_count_d = count_q;
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
                grant_d = '0;
                ptr_d   = w_ptr_next;
            end
            default: begin
                state_d = C_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= C_IDLE;
            grant_q      <= '0;
            runner_q     <= '0;
            count_q      <= '0;
            done_q       <= 1'b0;
            done_id_q    <= '0;
            done_count_q <= '0;
            ptr_q        <= '0;
            cur_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            runner_q     <= runner_d;
            count_q      <= count_d;
            done_q       <= done_d;
            done_id_q    <= done_id_d;
            done_count_q <= done_count_d;
            ptr_q        <= ptr_d;
            cur_id_q     <= cur_id_d;
        end
    end

`ifdef COUNTDOWN_SCHED_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            if ((state_q == C_RUN) && (runner_q != '0)) begin
                $display("count=%d  runner=%d", count_q, runner_q);
            end
            if (state_q == C_DONE) begin
                $display("Final count=%d id=%d", done_count_q, done_id_q);
            end
        end
    end
`else
    // Trace disabled: no display logic is built.
`endif

    assign grant      = grant_q;
    assign busy       = (state_q == C_RUN) || (state_q == C_DONE);
    assign runner     = runner_q;
    assign count      = count_q;
    assign done       = done_q;
    assign done_id    = done_id_q;
    assign done_count = done_count_q;

endmodule
`default_nettype wire

// File: doc/countdown_sched.md
Name: countdown_sched

Overview:
- Scheduler that shares one countdown/accumulate engine (runner decrements, count increments, one step per cycle) among NREQ requesters.
- Each requester asks for a run of a given length. A round-robin arbiter grants one requester at a time. The engine runs that job to completion, then reports the final count and the requester ID.
- Sits in the scheduling regression suite as the synchronous, arbitrated replacement for event-triggered countdown loops.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LW, 8, width of run length / runner register
- CW, 32, width of count accumulator
- IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ

Ports:
- clk  input  1  single clock, all state on posedge
- rst  input  1  synchronous reset, active-high
- req  input  NREQ  level request per requester; held until its done pulse
- req_len  input  NREQ*LW  run length per requester; slice i = [i*LW +: LW]; sampled on grant
- grant  output  NREQ  one-hot, high for the granted requester from accept through DONE
- busy  output  1  high in RUN and DONE
- runner  output  LW  current remaining steps
- count  output  CW  current accumulated steps
- done  output  1  one-cycle pulse when a job completes
- done_id  output  IDW  index of completed requester; valid with done, held afterwards
- done_count  output  CW  final count of completed job; valid with done, held afterwards

Behaviour:
- Reset values:
  - State = IDLE; grant = 0; busy = 0; runner = 0; count = 0; done = 0; done_id = 0; done_count = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If any req is set, pick the first set req at or after the pointer (wrapping modulo NREQ).
  - Next cycle: grant[i] = 1, runner = req_len slice i, count = 0, state = RUN.
  - If no req is set, stay in IDLE; all outputs hold.
- RUN, runner != 0: per cycle, runner <= runner - 1 and count <= count + 1.
- RUN, runner == 0: state <= DONE; done <= 1, done_id <= i, done_count <= count.
- DONE (one cycle):
  - grant cleared on exit.
  - Pointer <= (i + 1) mod NREQ.
  - state <= IDLE.
  - The requester must drop req in the cycle it sees done. A req still high in IDLE is treated as a new job.
- Latency for a job of length L:
  - Accept edge at cycle t.
  - done high in cycle t + L + 1.
  - done_count = L.
  - Next accept no earlier than t + L + 3.
- L = 0: one RUN cycle with runner == 0; done_count = 0, and done asserts at t + 1.
- Width rules:
  - count wraps modulo 2**CW; it cannot wrap in practice since L <= 2**LW - 1.
  - runner never underflows: it only decrements when nonzero.
- Arbitration and request-line rules:
  - req changes during RUN are ignored; req_len is sampled only at accept.
  - Simultaneous requests are served strictly round-robin. No requester is skipped twice while it is continuously requesting.
  - A req deasserted mid-job does not abort the job.
- rst asserted in any state (including mid-RUN):
  - All state returns to reset values on the next edge.
  - The in-flight job is discarded with no done pulse.

Optional Feature:
- Macro: COUNTDOWN_SCHED_TRACE_EN.
- When defined: each RUN cycle with runner != 0 executes $display("count=%d  runner=%d", count, runner). Each DONE executes $display("Final count=%d id=%d", done_count, done_id).
- When undefined: no display statements are compiled.
- Cycle behaviour is identical in both cases.

Test Plan:
- Reset then single job: req[0] = 1, len0 = 3 -> grant = 0001 next cycle; runner steps 3, 2, 1, 0 while count steps 0, 1, 2, 3; done = 1 with done_id = 0, done_count = 3 at accept + 4.
- Zero length: req[2] = 1, len2 = 0 -> done at accept + 1 with done_count = 0, done_id = 2.
- Round-robin fairness: all four req held, all lengths 2 -> completion order of done_id is 0, 1, 2, 3, 0; each done_count = 2; no double grant.
- Pointer wrap: after serving id 3, req[1] and req[3] both high -> id 1 granted first.
- Reset mid-run: len0 = 200, assert rst at RUN cycle 50 -> next cycle grant = 0, runner = 0, count = 0, done never pulses; a fresh req[0] then completes normally.
- Max length: len1 = 255 -> done_count = 255 at accept + 256; runner ends at 0 with no underflow.
